// File: rtl/led_matrix_scroller.sv
// Scrolling ROWS x COLS LED-matrix driver: one-hot column scan over a frame buffer that
// shifts in new columns from either side on a scroll tick, with a valid/ack handshake.
module led_matrix_scroller #(
    parameter int unsigned  COLS  = 5,
    parameter int unsigned  ROWS  = 7,
    localparam int unsigned IDX_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_tick,
    input  logic             scroll_tick,
    input  logic             dir,
    input  logic             pause,
    input  logic             clear,
    input  logic [ROWS-1:0]  col_in,
    input  logic             col_valid,
    output logic             col_ack,
    output logic [COLS-1:0]  col_sel,
    output logic [ROWS-1:0]  row_out,
    output logic [IDX_W-1:0] scan_idx,
    output logic             frame_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(COLS - 1);
    localparam logic [COLS-1:0]  OneHot0 = COLS'(1);

    logic [COLS-1:0][ROWS-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]          scan_idx_q, scan_idx_d;
    logic [COLS-1:0]           col_sel_q, col_sel_d;
    logic [ROWS-1:0]           row_out_q, row_out_d;
    logic                      col_ack_q, col_ack_d;
    logic                      frame_done_q, frame_done_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic                      last_dir_q, last_dir_d;

    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] cnt_base;
    logic [ROWS-1:0]  new_col;

    always_comb begin
        scan_idx_d   = scan_idx_q;
        col_sel_d    = col_sel_q;
        row_out_d    = row_out_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;
        last_dir_d   = last_dir_q;
        col_ack_d    = 1'b0;
        frame_done_d = 1'b0;

        next_idx = (scan_idx_q == LastIdx) ? '0 : scan_idx_q + 1'b1;
        new_col  = col_valid ? col_in : '0;
        // A direction change breaks the run of consecutive columns.
        cnt_base = (dir != last_dir_q) ? '0 : cnt_q;

        // Scan samples frame_q, so a shift on the same edge shows up one scan later.
        if (scan_tick) begin
            scan_idx_d = next_idx;
            col_sel_d  = OneHot0 << next_idx;
            row_out_d  = frame_q[next_idx];
        end

        if (clear) begin
            frame_d = '0;
            cnt_d   = '0;
        end else if (scroll_tick && !pause) begin
            frame_d    = dir ? {frame_q[COLS-2:0], new_col} : {new_col, frame_q[COLS-1:1]};
            last_dir_d = dir;
            if (col_valid) begin
                col_ack_d = 1'b1;
                if (cnt_base == LastIdx) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_base + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q      <= '0;
            scan_idx_q   <= LastIdx;
            col_sel_q    <= '0;
            row_out_q    <= '0;
            col_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
            last_dir_q   <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            scan_idx_q   <= scan_idx_d;
            col_sel_q    <= col_sel_d;
            row_out_q    <= row_out_d;
            col_ack_q    <= col_ack_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            last_dir_q   <= last_dir_d;
        end
    end

    assign col_ack    = col_ack_q;
    assign col_sel    = col_sel_q;
    assign row_out    = row_out_q;
    assign scan_idx   = scan_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scroller.sv
// Scoreboard bench for led_matrix_scroller (COLS=5, ROWS=7): a behavioural model queues the
// expected outputs of every cycle; each scenario task compares them against the sampled DUT.
module tb_led_matrix_scroller;

    localparam int COLS = 5;
    localparam int ROWS = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            scan_tick, scroll_tick, dir, pause, clear, col_valid;
    logic [ROWS-1:0] col_in;
    logic            col_ack, frame_done;
    logic [COLS-1:0] col_sel;
    logic [ROWS-1:0] row_out;
    logic [2:0]      scan_idx;

    led_matrix_scroller #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_tick  (scan_tick),
        .scroll_tick(scroll_tick),
        .dir        (dir),
        .pause      (pause),
        .clear      (clear),
        .col_in     (col_in),
        .col_valid  (col_valid),
        .col_ack    (col_ack),
        .col_sel    (col_sel),
        .row_out    (row_out),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [COLS-1:0] sel;
        logic [ROWS-1:0] row;
        logic [2:0]      idx;
        logic            ack;
        logic            done;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [ROWS-1:0] m_frame[COLS];
    logic [2:0]      m_idx;
    logic [COLS-1:0] m_sel;
    logic [ROWS-1:0] m_row;
    int              m_cnt;
    logic            m_last_dir;

    task automatic model_reset();
        for (int i = 0; i < COLS; i++) m_frame[i] = '0;
        m_idx      = 3'd4;
        m_sel      = '0;
        m_row      = '0;
        m_cnt      = 0;
        m_last_dir = 1'b0;
    endtask

    // Drives one clock edge worth of inputs, predicts the result, and samples the DUT.
    task automatic step(input logic sc, input logic sr, input logic d, input logic p,
                        input logic clr, input logic v, input logic [ROWS-1:0] c);
        obs_t            e;
        obs_t            o;
        logic [2:0]      ni;
        logic [ROWS-1:0] nc;
        @(negedge clk);
        scan_tick = sc; scroll_tick = sr; dir = d; pause = p; clear = clr;
        col_valid = v; col_in = c;
        e.ack  = 1'b0;
        e.done = 1'b0;
        if (sc) begin
            ni    = (m_idx == 3'd4) ? 3'd0 : m_idx + 3'd1;
            m_sel = 5'b00001 << ni;
            m_row = m_frame[ni];
            m_idx = ni;
        end
        if (clr) begin
            for (int i = 0; i < COLS; i++) m_frame[i] = '0;
            m_cnt = 0;
        end else if (sr && !p) begin
            nc = v ? c : '0;
            if (!d) begin
                for (int i = 0; i < COLS - 1; i++) m_frame[i] = m_frame[i+1];
                m_frame[COLS-1] = nc;
            end else begin
                for (int i = COLS - 1; i > 0; i--) m_frame[i] = m_frame[i-1];
                m_frame[0] = nc;
            end
            if (v) begin
                e.ack = 1'b1;
                if (d != m_last_dir) m_cnt = 0;
                if (m_cnt == COLS - 1) begin
                    e.done = 1'b1;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0;
            end
            m_last_dir = d;
        end
        e.sel = m_sel;
        e.row = m_row;
        e.idx = m_idx;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = {col_sel, row_out, scan_idx, col_ack, frame_done};
        obs_q.push_back(o);
        scan_tick = 0; scroll_tick = 0; clear = 0; col_valid = 0;
    endtask

    task automatic scan_cycle();
        for (int i = 0; i < COLS; i++) step(1, 0, dir, 0, 0, 0, '0);
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst = 1'b0;
        scan_tick = 0; scroll_tick = 0; dir = 0; pause = 0; clear = 0;
        col_valid = 0; col_in = '0;
        model_reset();
        #12;
        checks++;
        if (col_sel !== 5'b0 || row_out !== 7'h0 || scan_idx !== 3'd4 || col_ack !== 1'b0
            || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%b row=%h idx=%0d ack=%b done=%b, expected 00000 00 4 0 0",
                     col_sel, row_out, scan_idx, col_ack, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_scan: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    task automatic test_scroll_left();
        obs_t            e, o;
        logic [ROWS-1:0] pat[5];
        pat[0] = 7'h7F; pat[1] = 7'h01; pat[2] = 7'h02; pat[3] = 7'h04; pat[4] = 7'h08;
        dir = 0;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, pat[i]);
        scan_cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scroll_left: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    task automatic test_scroll_right_blank();
        obs_t e, o;
        step(0, 0, 1, 0, 1, 0, '0);
        step(0, 1, 1, 0, 0, 1, 7'h11);
        step(0, 1, 1, 0, 0, 0, 7'h7F);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 1, 7'(8'h21 + i));
        dir = 1;
        scan_cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scroll_right: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 1, 7'h5A);
        pause = 0;
        scan_cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pause: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    task automatic test_clear_and_collision();
        obs_t e, o;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 7'(7'h31 + i));
        step(0, 1, 0, 0, 1, 1, 7'h7F);
        dir = 0;
        scan_cycle();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 7'(7'h41 + 3 * i));
        while (m_idx != 3'd3) step(1, 0, 0, 0, 0, 0, '0);
        step(1, 1, 0, 0, 0, 1, 7'h55);
        scan_cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clear_collision: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) != 0),
                 7'($urandom));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 7'(7'h0F + i));
        step(1, 0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (col_sel !== 5'b0 || row_out !== 7'h0 || scan_idx !== 3'd4) begin
            errors++;
            $display("FAIL reset_async: sel=%b row=%h idx=%0d, expected 00000 00 4",
                     col_sel, row_out, scan_idx);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        dir = 0;
        scan_cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid: got sel=%b row=%h idx=%0d ack=%b done=%b, expected sel=%b row=%h idx=%0d ack=%b done=%b",
                         o.sel, o.row, o.idx, o.ack, o.done, e.sel, e.row, e.idx, e.ack, e.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scroll_left();
        test_scroll_right_blank();
        test_pause();
        test_clear_and_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_matrix_scroller.md
Name: led_matrix_scroller

Overview:
- Parametrised ROWS x COLS LED-matrix driver with a scrolling frame buffer. Successor to the fixed 5x7 column-scan matrix.
- Time-multiplexes one-hot column selects with the matching row pattern.
- Shifts new column data into the frame in either direction on a scroll tick, with pause, clear, a valid/ack column handshake and a frame-replaced indication.
- Runs on one system clock; the scan and scroll rates come from single-cycle enable ticks generated upstream by the clock divider.

Parameters:
- COLS, 5, number of matrix columns (>=2).
- ROWS, 7, number of matrix rows (>=1).
- IDX_W, $clog2(COLS), width of scan index and shift counter (localparam, derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- scan_tick  in  1  single-cycle enable; advances the column scan.
- scroll_tick  in  1  single-cycle enable; shifts the frame by one column.
- dir  in  1  0 = scroll left (new column enters at COLS-1); 1 = scroll right (enters at 0).
- pause  in  1  1 = scroll_tick ignored; scanning continues.
- clear  in  1  synchronous frame clear.
- col_in  in  ROWS  incoming column; bit ROWS-1 = top row.
- col_valid  in  1  col_in holds valid data.
- col_ack  out  1  one-cycle pulse: col_in consumed this cycle.
- col_sel  out  COLS  one-hot active-high column select.
- row_out  out  ROWS  row drive for the selected column; bit ROWS-1 = top row.
- scan_idx  out  IDX_W  currently displayed column index.
- frame_done  out  1  one-cycle pulse when COLS consecutive valid columns have been shifted in.

Behaviour:
- Reset (rst=0, async):
  - frame buffer all 0; scan_idx = COLS-1; col_sel = 0 (blanked); row_out = 0.
  - col_ack = 0; frame_done = 0; shift counter = 0.
- Scan (registered, latency 1):
  - On scan_tick: scan_idx <= (scan_idx==COLS-1) ? 0 : scan_idx+1.
  - Same edge: col_sel <= onehot(next idx); row_out <= frame[next idx].
  - Without scan_tick, col_sel, row_out and scan_idx hold.
  - The first scan_tick after reset selects column 0.
- Scroll (frame update on a clk edge where scroll_tick=1, pause=0, clear=0):
  - dir=0: frame[c] <= frame[c+1] for c<COLS-1; frame[COLS-1] <= col_valid ? col_in : 0.
  - dir=1: frame[c] <= frame[c-1] for c>0; frame[0] <= col_valid ? col_in : 0.
  - col_ack <= 1 for one cycle only when col_valid=1; otherwise a blank column is inserted and col_ack stays 0.
- Shift counter:
  - Increments on each accepted valid column.
  - On reaching COLS-1 with another valid shift: frame_done pulses, counter wraps to 0.
  - A blank insertion, clear, or change of dir since the last shift resets the counter to 0.
- Priority: clear > scroll. clear=1 zeroes the frame and the shift counter; scroll_tick that cycle is ignored and col_ack=0. clear does not affect scan state.
- pause=1: scroll_tick has no effect (no shift, no ack, counter held).
- Simultaneous scan_tick and scroll_tick: row_out samples the pre-shift frame; the shifted data appears on the next scan_tick.
- row_out is not re-sampled between scan_ticks, even if the frame changes.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan (COLS=5, ROWS=7):
- Reset then 6 scan_ticks -> col_sel 00001, 00010, 00100, 01000, 10000, 00001; row_out = 0 throughout; scan_idx 0..4..0.
- dir=0: shift 7'h7F, 7'h01, 7'h02, 7'h04, 7'h08 with col_valid=1 -> frame = {7F,01,02,04,08} (col0..col4); 5 col_ack pulses; frame_done pulses on the 5th shift; a scan cycle shows row_out 7F,01,02,04,08.
- dir=1: shift 7'h11 into a cleared frame -> frame[0]=11, others 0. Then one scroll_tick with col_valid=0 -> frame[1]=11, frame[0]=0, no col_ack, shift counter reset (no frame_done after 4 further valid shifts).
- pause=1 with 3 scroll_ticks and col_valid=1 -> frame unchanged, col_ack never asserted; scanning continues normally.
- clear and scroll_tick in the same cycle, frame full -> frame all 0, col_ack=0. scan_tick and scroll_tick in the same cycle selecting column 4 with dir=0 -> row_out shows the old frame[4].
- Assert rst mid-scan (between clk edges) -> col_sel=0, row_out=0, scan_idx=4 immediately; next scan_tick after release selects column 0.
